// File: rtl/alu_control_md_pkg.sv
// Shared encodings for the mipslite ALU control decoder and its multiply/divide unit.
// The decode helper maps the main-decoder op and R-type function field to an ALU control word.
package alu_control_md_pkg;

  localparam int ALU_CONLROL_LENGTH = 3;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_R_TYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ORI    = 2'b11;

  localparam logic [ALU_CONLROL_LENGTH-1:0] ALU_CONLROL_ADD  = 3'd0;
  localparam logic [ALU_CONLROL_LENGTH-1:0] ALU_CONLROL_ADDU = 3'd1;
  localparam logic [ALU_CONLROL_LENGTH-1:0] ALU_CONLROL_SUBU = 3'd2;
  localparam logic [ALU_CONLROL_LENGTH-1:0] ALU_CONLROL_ORI  = 3'd3;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;
  localparam logic [5:0] FUNC_ADDU  = 6'h21;
  localparam logic [5:0] FUNC_SUBU  = 6'h23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic [ALU_CONLROL_LENGTH-1:0] alu_decode(
    input logic [1:0] aluop,
    input logic [5:0] func
  );
    logic [ALU_CONLROL_LENGTH-1:0] ctl;
    ctl = ALU_CONLROL_ADDU;
    case (aluop)
      ALU_OP_ADD:    ctl = ALU_CONLROL_ADD;
      ALU_OP_SUB:    ctl = ALU_CONLROL_SUBU;
      ALU_OP_ORI:    ctl = ALU_CONLROL_ORI;
      // R-type funcs other than SUBU are don't-care for the ALU; ADDU keeps it benign
      ALU_OP_R_TYPE: ctl = (func == FUNC_SUBU) ? ALU_CONLROL_SUBU : ALU_CONLROL_ADDU;
      default:       ctl = ALU_CONLROL_ADDU;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_control_md_md_iter.sv
// Iterative 1-bit/cycle unsigned multiply (shift-add) and restoring divide datapath.
// res_hi/res_lo carry the value after the current step, so they are the final result while done is high.
module md_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             step,
  input  logic             abort,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] oper_q, oper_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             no_borrow;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  // MUL: acc_lo holds the multiplier, oper the multiplicand; DIV: acc_lo holds dividend/quotient, oper the divisor
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + ({1'b0, oper_q} & {(WIDTH+1){acc_lo_q[0]}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    no_borrow = (div_shift >= {1'b0, oper_q});
    div_diff  = div_shift[WIDTH-1:0] - oper_q;
    if (op_div_q) begin
      nxt_hi = no_borrow ? div_diff : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo_q[WIDTH-2:0], no_borrow};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    oper_d   = oper_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    if (start) begin
      acc_hi_d = '0;
      acc_lo_d = op_div ? opa : opb;
      oper_d   = op_div ? opb : opa;
      cnt_d    = CNT_W'(WIDTH - 1);
      op_div_d = op_div;
    end else if (abort) begin
      cnt_d = '0;
    end else if (step) begin
      acc_hi_d = nxt_hi;
      acc_lo_d = nxt_lo;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      oper_q   <= '0;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      oper_q   <= oper_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
    end
  end

  assign done   = (cnt_q == '0);
  assign res_hi = nxt_hi;
  assign res_lo = nxt_lo;

endmodule

// File: rtl/alu_control_md.sv
// ALU control decoder with HI/LO registers and an iterative MULTU/DIVU unit that stalls the pipeline.
// Stall covers the issue cycle plus WIDTH iteration cycles; a one-cycle DONE lets the held instruction retire.
module alu_control_md
  import alu_control_md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  input  logic                          flush,
  input  logic [1:0]                    aluop,
  input  logic [5:0]                    func,
  input  logic [WIDTH-1:0]              rs_val,
  input  logic [WIDTH-1:0]              rt_val,
  output logic [ALU_CONLROL_LENGTH-1:0] alu_conlrol,
  output logic                          stall,
  output logic                          md_busy,
  output logic [WIDTH-1:0]              mf_data,
  output logic                          mf_sel,
  output logic [WIDTH-1:0]              hi,
  output logic [WIDTH-1:0]              lo
);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             md_busy_q, md_busy_d;

  logic             is_r, live, start, it_done;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign is_r = (aluop == ALU_OP_R_TYPE);
  assign live = valid & ~flush & is_r;
  assign start = rst_n & live & (state_q == ST_IDLE)
               & ((func == FUNC_MULTU) | (func == FUNC_DIVU));

  assign alu_conlrol = alu_decode(aluop, func);

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_div (func == FUNC_DIVU),
    .step   (md_busy_q & ~flush),
    .abort  (md_busy_q & flush),
    .opa    (rs_val),
    .opb    (rt_val),
    .done   (it_done),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    md_busy_d = md_busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = (func == FUNC_DIVU) ? ST_DIV : ST_MUL;
          md_busy_d = 1'b1;
        end else if (live) begin
          if (func == FUNC_MTHI) hi_d = rs_val;
          if (func == FUNC_MTLO) lo_d = rs_val;
        end
      end
      ST_MUL, ST_DIV: begin
        // a flush on the last iteration still discards the result
        if (flush) begin
          state_d   = ST_IDLE;
          md_busy_d = 1'b0;
        end else if (it_done) begin
          hi_d      = res_hi;
          lo_d      = res_lo;
          state_d   = ST_DONE;
          md_busy_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      md_busy_q <= md_busy_d;
    end
  end

  assign stall   = start | md_busy_q;
  assign md_busy = md_busy_q;
  assign mf_sel  = valid & is_r & ((func == FUNC_MFHI) | (func == FUNC_MFLO));
  assign mf_data = (func == FUNC_MFHI) ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_control_md.sv
// Scoreboard bench for alu_control_md: 32-bit and 8-bit instances, directed vectors.
module tb_alu_control_md;
  import alu_control_md_pkg::*;

  localparam int K_ALU  = 0;
  localparam int K_MF   = 1;
  localparam int K_IDLE = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        valid, flush, obs;
  logic [1:0]  aluop;
  logic [5:0]  func;
  logic [31:0] rs_val, rt_val;
  logic [ALU_CONLROL_LENGTH-1:0] alu_conlrol;
  logic        stall, md_busy, mf_sel;
  logic [31:0] mf_data, hi, lo;

  logic        v8, f8;
  logic [1:0]  aluop8;
  logic [5:0]  func8;
  logic [7:0]  rs8, rt8, mf_data8, hi8, lo8;
  logic [ALU_CONLROL_LENGTH-1:0] alu_conlrol8;
  logic        stall8, md_busy8, mf_sel8;

  alu_control_md #(.WIDTH(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .aluop(aluop), .func(func),
    .rs_val(rs_val), .rt_val(rt_val), .alu_conlrol(alu_conlrol), .stall(stall),
    .md_busy(md_busy), .mf_data(mf_data), .mf_sel(mf_sel), .hi(hi), .lo(lo)
  );

  alu_control_md #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .valid(v8), .flush(f8), .aluop(aluop8), .func(func8),
    .rs_val(rs8), .rt_val(rt8), .alu_conlrol(alu_conlrol8), .stall(stall8),
    .md_busy(md_busy8), .mf_data(mf_data8), .mf_sel(mf_sel8), .hi(hi8), .lo(lo8)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t cq[$];
  exp_t mq[$];
  exp_t mq8[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] b, input int stl, input int which);
    exp_t e;
    e.kind = k; e.a = a; e.b = b; e.stl = stl;
    if (which == 0) cq.push_back(e);
    else if (which == 1) mq.push_back(e);
    else mq8.push_back(e);
  endtask

  // Combinational-output monitor: pops one expectation per observed cycle
  exp_t ce;
  always @(negedge clk) begin
    if (obs === 1'b1) begin
      if (cq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL comb_pop: output observed with no expectation queued");
      end else begin
        ce = cq.pop_front();
        case (ce.kind)
          K_ALU: begin
            chk("alu_conlrol", 32'(alu_conlrol), ce.a);
            chk("alu_stall", 32'(stall), 32'd0);
          end
          K_MF: begin
            chk("mf_data", mf_data, ce.a);
            chk("mf_sel", 32'(mf_sel), 32'd1);
          end
          default: begin
            chk("idle_hi", hi, ce.a);
            chk("idle_lo", lo, ce.b);
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_busy", 32'(md_busy), 32'd0);
          end
        endcase
      end
    end
  end

  // Multiply/divide monitor: the falling edge of md_busy presents a result
  exp_t me;
  bit   busy_prev;
  int   stl_cnt = 0;
  always @(negedge clk) begin
    if (busy_prev && md_busy === 1'b0) begin
      if (mq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL md_pop: md_busy fell with no expectation queued");
      end else begin
        me = mq.pop_front();
        chk("md_hi", hi, me.a);
        chk("md_lo", lo, me.b);
        chk("md_stall_after", 32'(stall), 32'd0);
        if (me.stl >= 0) chk("md_stall_cycles", 32'(stl_cnt), 32'(me.stl));
      end
    end
    stl_cnt   = (stall === 1'b1) ? stl_cnt + 1 : 0;
    busy_prev = (md_busy === 1'b1);
  end

  exp_t me8;
  bit   busy8_prev;
  int   stl8_cnt = 0;
  always @(negedge clk) begin
    if (busy8_prev && md_busy8 === 1'b0) begin
      if (mq8.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL md8_pop: md_busy fell with no expectation queued");
      end else begin
        me8 = mq8.pop_front();
        chk("md8_hi", 32'(hi8), me8.a);
        chk("md8_lo", 32'(lo8), me8.b);
        chk("md8_stall_cycles", 32'(stl8_cnt), 32'(me8.stl));
      end
    end
    stl8_cnt   = (stall8 === 1'b1) ? stl8_cnt + 1 : 0;
    busy8_prev = (md_busy8 === 1'b1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid = 0; flush = 0; obs = 0; aluop = ALU_OP_ADD; func = 6'h00;
    v8 = 0; f8 = 0; aluop8 = ALU_OP_ADD; func8 = 6'h00;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] r);
    valid = 1; aluop = op; func = f; rs_val = r;
    tick();
    idle();
  endtask

  task automatic comb_vec(input int k, input logic [1:0] op, input logic [5:0] f, input logic [31:0] ea);
    push(k, ea, 32'd0, 0, 0);
    valid = 1; aluop = op; func = f; obs = 1;
    tick();
    idle();
  endtask

  task automatic idle_chk(input logic [31:0] eh, input logic [31:0] el);
    push(K_IDLE, eh, el, 0, 0);
    obs = 1;
    tick();
    obs = 0;
  endtask

  // Hold a MULTU/DIVU until stall drops, then let the DONE cycle retire it
  task automatic md_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    bit seen;
    push(K_IDLE, eh, el, 33, 1);
    valid = 1; aluop = ALU_OP_R_TYPE; func = f; rs_val = a; rt_val = b;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (stall === 1'b0) begin seen = 1; break; end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL md_timeout: stall still high after 100 cycles, expected low after 33");
    end
    tick();
    idle();
  endtask

  task automatic md_op8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    bit seen;
    push(K_IDLE, eh, el, 9, 2);
    v8 = 1; aluop8 = ALU_OP_R_TYPE; func8 = f; rs8 = a; rt8 = b;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (stall8 === 1'b0) begin seen = 1; break; end
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL md8_timeout: stall still high after 50 cycles, expected low after 9");
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    rs_val = 0; rt_val = 0; rs8 = 0; rt8 = 0;
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    idle_chk(32'd0, 32'd0);

    comb_vec(K_ALU, ALU_OP_R_TYPE, FUNC_ADDU, 32'(ALU_CONLROL_ADDU));
    comb_vec(K_ALU, ALU_OP_R_TYPE, FUNC_SUBU, 32'(ALU_CONLROL_SUBU));
    comb_vec(K_ALU, ALU_OP_ORI,    6'h00,     32'(ALU_CONLROL_ORI));
    comb_vec(K_ALU, ALU_OP_ADD,    6'h00,     32'(ALU_CONLROL_ADD));
    comb_vec(K_ALU, ALU_OP_SUB,    6'h00,     32'(ALU_CONLROL_SUBU));
    comb_vec(K_ALU, ALU_OP_R_TYPE, 6'h24,     32'(ALU_CONLROL_ADDU));

    md_op(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    comb_vec(K_MF, ALU_OP_R_TYPE, FUNC_MFHI, 32'hFFFF_FFFE);
    comb_vec(K_MF, ALU_OP_R_TYPE, FUNC_MFLO, 32'h0000_0001);

    md_op(FUNC_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    md_op(FUNC_DIVU, 32'd5,   32'd0, 32'd5, 32'hFFFF_FFFF);

    issue(ALU_OP_R_TYPE, FUNC_MTLO, 32'h1234);
    comb_vec(K_MF, ALU_OP_R_TYPE, FUNC_MFLO, 32'h1234);

    // Reset during an active MULTU discards it
    push(K_IDLE, 32'd0, 32'd0, -1, 1);
    valid = 1; aluop = ALU_OP_R_TYPE; func = FUNC_MULTU; rs_val = 32'd3; rt_val = 32'd5;
    repeat (10) tick();
    rst_n = 0; idle();
    tick();
    rst_n = 1;
    idle_chk(32'd0, 32'd0);

    // Flush during a DIVU leaves preloaded HI/LO untouched
    issue(ALU_OP_R_TYPE, FUNC_MTHI, 32'hA);
    issue(ALU_OP_R_TYPE, FUNC_MTLO, 32'hB);
    push(K_IDLE, 32'hA, 32'hB, -1, 1);
    valid = 1; aluop = ALU_OP_R_TYPE; func = FUNC_DIVU; rs_val = 32'd100; rt_val = 32'd7;
    repeat (5) tick();
    flush = 1;
    tick();
    idle();
    idle_chk(32'hA, 32'hB);

    md_op(FUNC_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);

    // Flush in the would-be start cycle suppresses the start
    push(K_IDLE, 32'd0, 32'd42, 0, 0);
    valid = 1; flush = 1; aluop = ALU_OP_R_TYPE; func = FUNC_MULTU; rs_val = 32'd9; rt_val = 32'd9; obs = 1;
    tick();
    idle();
    idle_chk(32'd0, 32'd42);

    md_op8(FUNC_MULTU, 8'hFF, 8'h02, 32'h01, 32'hFE);
    md_op8(FUNC_DIVU,  8'd200, 8'd9, 32'd2, 32'd22);

    repeat (3) tick();
    chk("pending_comb", 32'(cq.size()), 32'd0);
    chk("pending_md", 32'(mq.size()), 32'd0);
    chk("pending_md8", 32'(mq8.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder for the mipslite core.
- Decodes `aluop`/`func` to the ALU control word as before.
- Adds a sequential multiply/divide path: MULTU, DIVU, MFHI, MFLO, MTHI and MTLO, with HI/LO registers.
- Drives a stall handshake to the pipeline while an iterative operation runs.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥ 4.
- CNT_W, $clog2(WIDTH), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- valid  in  1  EX-stage instruction is live
- flush  in  1  cancel the EX-stage instruction
- aluop  in  2  main-decoder ALU op
- func  in  6  R-type function field
- rs_val  in  WIDTH  operand A (multiplicand or dividend)
- rt_val  in  WIDTH  operand B (multiplier or divisor)
- alu_conlrol  out  `ALU_CONLROL_LENGTH  ALU control word
- stall  out  1  hold IF/ID/EX this cycle
- md_busy  out  1  iterative unit active
- mf_data  out  WIDTH  HI or LO value for MFHI/MFLO
- mf_sel  out  1  EX result comes from `mf_data` rather than the ALU
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, `rst_n` low at a clk edge):
  - state=IDLE; `hi`, `lo` = 0; counter=0; `stall`=0; `md_busy`=0.
  - Takes priority over every other event, including mid-operation: any in-flight result is discarded.
- `alu_conlrol`: combinational.
  - ADD→ADD; SUB→SUBU; ORI→ORI.
  - R_TYPE: ADDU→ADDU, SUBU→SUBU; any other func→ADDU (don't-care default).
- `start` = valid & !flush & aluop==R_TYPE & func∈{MULTU 6'h19, DIVU 6'h1B} & state==IDLE.
- FSM states:
  - IDLE: on `start`, latch operands, counter=WIDTH-1, go to MUL or DIV. `stall`=1 combinationally in the start cycle.
  - MUL: shift-add, 1 bit/cycle. 2·WIDTH-bit accumulator {acc_hi, multiplier}. If lsb=1, acc_hi += multiplicand with carry. Shift right 1.
  - DIV: restoring divide, 1 bit/cycle. Remainder shifted left with the next dividend bit. Trial subtract the divisor; if no borrow, commit and set quotient bit 1, else 0.
  - MUL/DIV: `stall`=1, `md_busy`=1. When counter==0, write HI/LO and go to DONE; else decrement the counter.
  - DONE: `stall`=0, `md_busy`=0, exactly one cycle, then IDLE. The still-held MULTU/DIVU advances without restarting, because start requires IDLE.
- Timing:
  - Issue cycle T: stall=1.
  - Cycles T+1..T+WIDTH: stall=1.
  - New HI/LO are visible at T+WIDTH+1.
  - Total stall = WIDTH+1 cycles.
- Results:
  - MULTU: {hi,lo} = 2·WIDTH-bit unsigned product.
  - DIVU: lo=quotient, hi=remainder.
  - Divide by zero: lo=all ones, hi=dividend. Deterministic; no exception.
- MTHI/MTLO (6'h11/6'h13): when valid & !flush & state==IDLE, write rs_val into hi/lo at the clock edge.
- MFHI/MFLO (6'h10/6'h12):
  - `mf_sel`=1; `mf_data`=hi or lo, combinational from the registers.
  - In the same cycle as a DONE write, the register output reflects the completed result; no bypass is needed beyond register timing.
- Flush:
  - In the start cycle: suppresses start.
  - In MUL/DIV: abort to IDLE next cycle; HI/LO unchanged; stall drops the cycle after flush.
- `valid`=0: no state change from decode; an in-progress operation continues.

Decomposition:
- head.v gains FUNC_MULTU, FUNC_DIVU, FUNC_MFHI, FUNC_MFLO, FUNC_MTHI and FUNC_MTLO.
- FSM state encodings live in head.v.
- The existing ALU_OP_* and ALU_CONLROL_* defines are reused unchanged.
- One sub-module, `md_iter`: datapath (accumulator, counter, MUL/DIV step logic) with start/done/abort ports.
- The FSM, decode and HI/LO live in the top module.
- The MuxKey library is used for the combinational decode.

Test Plan:
- aluop=R_TYPE, func=ADDU, then SUBU; aluop=ORI → alu_conlrol = ADDU, SUBU, ORI respectively; stall=0 throughout.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF held with valid → stall high exactly 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001. A following MFHI gives mf_data=0xFFFFFFFE with mf_sel=1.
- DIVU rs=100, rt=7 → hi=2, lo=14 after 33 stall cycles. DIVU rs=5, rt=0 → lo=0xFFFFFFFF, hi=5.
- MTLO rs=0x1234 in IDLE, then MFLO → mf_data=0x1234. Assert rst_n=0 mid-MULTU (cycle 10) → next cycle stall=0, hi=lo=0, state IDLE.
- flush in cycle 5 of a DIVU with hi/lo preloaded 0xA/0xB → stall deasserts next cycle; hi=0xA, lo=0xB unchanged; a new MULTU then starts normally.
- WIDTH=8 instance: MULTU 0xFF×0x02 → hi=0x01, lo=0xFE; stall lasts 9 cycles.
